// File: rtl/cryptoveril_pkg.sv
// Shared constants and helpers for the cryptoveril round pipeline.
// Optional decrypt path is enabled with CRYPTOVERIL_DECRYPT_EN.
package cryptoveril_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int KEY_W_DEF  = 5;
    localparam int ROUNDS_DEF = 3;

    // Helpers work on a fixed 64-bit container; callers pass the live width.
    localparam int MAX_W = 64;
    typedef logic [MAX_W-1:0] word_t;

    // Additive round constant for round i.
    function automatic int unsigned rnd_const(input int unsigned i);
        return i + 1;
    endfunction

    // Rotation amount for round i: (key + i) mod w.
    function automatic int unsigned rot_amt(input word_t key, input int unsigned i,
                                            input int unsigned w);
        word_t s;
        s = key + word_t'(i);
        return 32'(s % word_t'(w));
    endfunction

    // Rotate the low w bits of x left by amt (amt < w); upper bits come back 0.
    function automatic word_t rotl(input word_t x, input int unsigned amt,
                                   input int unsigned w);
        word_t       r;
        int unsigned j;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                j = i + amt;
                if (j >= w) j = j - w;
                r[j[5:0]] = x[i[5:0]];
            end
        end
        return r;
    endfunction

    // Rotate right expressed as the complementary left rotation.
    function automatic word_t rotr(input word_t x, input int unsigned amt,
                                   input int unsigned w);
        return rotl(x, (amt == 0) ? 0 : (w - amt), w);
    endfunction

endpackage

// File: rtl/cryptoveril_round.sv
// One pipeline stage: combinational round IDX feeding the stage register.
// With CRYPTOVERIL_DECRYPT_EN a mode bit travels with the word and selects
// the inverse of round ROUNDS-1-IDX instead.
import cryptoveril_pkg::*;

module cryptoveril_round #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int KEY_W  = KEY_W_DEF,
`ifdef CRYPTOVERIL_DECRYPT_EN
    parameter int ROUNDS = ROUNDS_DEF,
`endif
    parameter int IDX    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv_i,
    input  logic              vld_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [KEY_W-1:0]  key_i,
`ifdef CRYPTOVERIL_DECRYPT_EN
    input  logic              mode_i,
    output logic              mode_o,
`endif
    output logic              vld_o,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] kexp;
    logic [DATA_W-1:0] enc_d;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;
    logic              vld_q;

    assign kexp = DATA_W'(key_i);

    // Forward round: rotl(x ^ kexp, r(IDX)) + (IDX+1).
    always_comb begin : enc_path
        word_t t;
        word_t rot;
        t     = word_t'(data_i ^ kexp);
        rot   = rotl(t, rot_amt(word_t'(key_i), IDX, DATA_W), DATA_W);
        enc_d = rot[DATA_W-1:0] + DATA_W'(rnd_const(IDX));
    end

`ifdef CRYPTOVERIL_DECRYPT_EN
    localparam int DEC_J = ROUNDS - 1 - IDX;
    logic [DATA_W-1:0] dec_d;
    logic              mode_q;

    // Inverse round DEC_J: rotr(x - (j+1), r(j)) ^ kexp.
    always_comb begin : dec_path
        word_t t;
        word_t rot;
        t     = word_t'(data_i - DATA_W'(rnd_const(DEC_J)));
        rot   = rotr(t, rot_amt(word_t'(key_i), DEC_J, DATA_W), DATA_W);
        dec_d = rot[DATA_W-1:0] ^ kexp;
    end

    assign data_d = mode_i ? dec_d : enc_d;
    assign mode_o = mode_q;

    // Mode bit moves with its word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       mode_q <= 1'b0;
        else if (adv_i) mode_q <= mode_i;
    end
`else
    assign data_d = enc_d;
`endif

    // Stage register: everything advances or everything holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (adv_i) begin
            vld_q  <= vld_i;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/cryptoveril_pipe.sv
// Cryptoveril pipeline top: ROUNDS stages with a global advance/stall,
// valid/ready handshake on both ends and a key register that only changes
// while the pipe is empty. Decrypt support: define CRYPTOVERIL_DECRYPT_EN.
import cryptoveril_pkg::*;

module cryptoveril_pipe #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int KEY_W  = KEY_W_DEF,
    parameter int ROUNDS = ROUNDS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
`ifdef CRYPTOVERIL_DECRYPT_EN
    input  logic              in_mode,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              key_err
);

    logic                           adv;
    logic                           acc;
    logic                           key_load;
    logic [KEY_W-1:0]               key_q;
    logic                           key_err_q;
    logic [ROUNDS-1:0]              stg_vld;
    logic [ROUNDS-1:0][DATA_W-1:0]  stg_dat;
    logic [ROUNDS-1:0]              in_vld_s;
    logic [ROUNDS-1:0][DATA_W-1:0]  in_dat_s;
`ifdef CRYPTOVERIL_DECRYPT_EN
    logic [ROUNDS-1:0]              stg_mode;
    logic [ROUNDS-1:0]              in_mode_s;
`endif

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign acc       = in_valid && adv;
    assign busy      = |stg_vld;
    assign out_valid = stg_vld[ROUNDS-1];
    assign out_data  = stg_dat[ROUNDS-1];
    assign key_err   = key_err_q;
    // Key may only change with nothing in flight and nothing entering.
    assign key_load  = ld && !busy && !acc;

    for (genvar g = 0; g < ROUNDS; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign in_vld_s[g]  = acc;
            assign in_dat_s[g]  = in_data;
`ifdef CRYPTOVERIL_DECRYPT_EN
            assign in_mode_s[g] = in_mode;
`endif
        end else begin : g_link
            assign in_vld_s[g]  = stg_vld[g-1];
            assign in_dat_s[g]  = stg_dat[g-1];
`ifdef CRYPTOVERIL_DECRYPT_EN
            assign in_mode_s[g] = stg_mode[g-1];
`endif
        end

        cryptoveril_round #(
            .DATA_W (DATA_W),
            .KEY_W  (KEY_W),
`ifdef CRYPTOVERIL_DECRYPT_EN
            .ROUNDS (ROUNDS),
`endif
            .IDX    (g)
        ) u_round (
            .clk    (clk),
            .rst    (rst),
            .adv_i  (adv),
            .vld_i  (in_vld_s[g]),
            .data_i (in_dat_s[g]),
            .key_i  (key_q),
`ifdef CRYPTOVERIL_DECRYPT_EN
            .mode_i (in_mode_s[g]),
            .mode_o (stg_mode[g]),
`endif
            .vld_o  (stg_vld[g]),
            .data_o (stg_dat[g])
        );
    end

    // Key register and one-cycle reject pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q     <= '0;
            key_err_q <= 1'b0;
        end else begin
            key_err_q <= ld && !key_load;
            if (key_load) key_q <= key_in;
        end
    end

endmodule

// File: doc/cryptoveril_pipe.md
CRYPTOVERIL_PIPE -- requirements
Module: cryptoveril_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning datapath width in bits (even, >= 8).
REQ-002 The block SHALL have parameter KEY_W, default 5, meaning key width in bits (KEY_W <= DATA_W).
REQ-003 The block SHALL have parameter ROUNDS, default 3, meaning number of pipeline round stages (1..16).
REQ-004 The block SHALL have port clk  input  1, meaning the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst  input  1, meaning an asynchronous, active-low reset.
REQ-006 The block SHALL have port ld  input  1, meaning a key load strobe.
REQ-007 The block SHALL have port key_in  input  KEY_W, meaning the key value captured on ld.
REQ-008 The block SHALL have port in_valid  input  1, meaning in_data is valid.
REQ-009 The block SHALL have port in_ready  output  1, meaning the block accepts in_data this cycle.
REQ-010 The block SHALL have port in_data  input  DATA_W, meaning the plaintext or ciphertext word.
REQ-011 The block SHALL have port in_mode  input  1, meaning 0=encrypt, 1=decrypt (present only with CRYPTOVERIL_DECRYPT_EN).
REQ-012 The block SHALL have port out_valid  output  1, meaning out_data is valid.
REQ-013 The block SHALL have port out_ready  input  1, meaning the consumer accepts out_data.
REQ-014 The block SHALL have port out_data  output  DATA_W, meaning the result word.
REQ-015 The block SHALL have port busy  output  1, meaning at least one pipeline stage holds a valid word.
REQ-016 The block SHALL have port key_err  output  1, meaning a one-cycle pulse when ld is rejected.

Function
REQ-017 kexp SHALL be key_reg zero-extended to DATA_W; r(i) SHALL be (key_reg + i) mod DATA_W.
REQ-018 Encrypt round i (0..ROUNDS-1) SHALL compute x' = rotl(x ^ kexp, r(i)) + (i+1), modulo 2^DATA_W with carry discarded.
REQ-019 Stage s SHALL register the result of round s, so latency from input handshake to out_valid is ROUNDS cycles when there is no stall.
REQ-020 The pipeline SHALL advance all stages together when adv = !out_valid || out_ready; otherwise every stage SHALL hold its value.
REQ-021 in_ready SHALL equal adv; a word SHALL be accepted only when in_valid && in_ready.
REQ-022 A cycle that advances without an accepted input SHALL insert a bubble with its valid bit at 0.
REQ-023 out_valid and out_data SHALL be the last stage's valid bit and data, both registered.
REQ-024 ld SHALL load key_reg only when busy=0 and no input is accepted in the same cycle.
REQ-025 An ld that is not loaded SHALL leave key_reg unchanged and pulse key_err for one cycle.
REQ-026 Results SHALL be throughput 1 word per cycle with no loss or duplication under any out_ready pattern.

Reset
REQ-027 While rst=0, all stage valid bits, out_valid, busy and key_err SHALL be 0, all data registers and key_reg SHALL be 0, and in_ready SHALL be 1.
REQ-028 An assertion of rst mid-stream SHALL discard all in-flight words with no output produced.

Configuration
REQ-029 With CRYPTOVERIL_DECRYPT_EN defined, each stage SHALL carry a mode bit captured from in_mode.
REQ-030 With CRYPTOVERIL_DECRYPT_EN defined, a decrypt word at stage s SHALL apply inverse round j = ROUNDS-1-s: x' = rotr(x - (j+1), r(j)) ^ kexp, so that decrypt(encrypt(d)) = d.
REQ-031 With CRYPTOVERIL_DECRYPT_EN undefined, the block SHALL omit the in_mode port and the mode logic, and SHALL be encrypt-only.

Structure
REQ-032 Package cryptoveril_pkg SHALL hold the default width constants, the round-constant function and the rotate helpers.
REQ-033 Each stage SHALL be an instance of the sub-module cryptoveril_round, with the round index as a parameter, generated ROUNDS times.

Verification
REQ-034 Default parameters, key=0, in_data=0x0001, out_ready=1 -> out_data=0x001B with out_valid high exactly 3 cycles after acceptance.
REQ-035 Default parameters, key=1, in_data=0x0000 -> out_data=0x005B.
REQ-036 Back-to-back inputs 0x0001, 0x0002, 0x0003 with out_ready held 0 for 5 cycles mid-stream -> all 3 results in order, no duplicates, and in_ready=0 while stalled.
REQ-037 ld with key_in=1 while busy=1 -> key_err pulses once, key_reg stays 0, and the in-flight result is 0x001B.
REQ-038 rst=0 asserted with 2 words in flight -> out_valid=0 and busy=0 immediately, with no output afterwards.
REQ-039 With CRYPTOVERIL_DECRYPT_EN defined, key=1, decrypt 0x005B -> 0x0000; 1000 random words encrypted then decrypted -> identity.
